// File: rtl/ram.sv
// Single-port 2048 x 64 memory: synchronous write, combinational read, one shared
// bidirectional data bus whose direction is chosen by isReading.
module ram #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  isReading,
  inout  wire  [0:DATA_WIDTH-1] data
);

  logic [0:DATA_WIDTH-1] ram_memory [DEPTH];

  logic drive_bus;

  // Bus ownership: the RAM owns data only while out of reset and isReading = 1;
  // otherwise the external driver owns it and the RAM presents high-Z.
  assign drive_bus = reset && isReading;
  assign data      = drive_bus ? ram_memory[address] : {DATA_WIDTH{1'bz}};

  // Reset clears every word and takes priority over a coincident write edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_memory[i] <= '0;
      end
    end else if (!isReading) begin
      ram_memory[address] <= data;
    end
  end

endmodule

// File: tb/tb_ram.sv
// Directed bench for ram: reset clearing, write/read-back, neighbour isolation,
// bus direction, no-write-while-reading, and asynchronous reset mid-run.
module tb_ram;

  localparam int AW = 11;
  localparam int DW = 64;

  logic          clk;
  logic          reset;
  logic [AW-1:0] address;
  logic          isReading;
  logic [DW-1:0] drv_val;
  logic          drv_en;
  wire  [DW-1:0] data;

  int total;
  int bad;

  assign data = drv_en ? drv_val : {DW{1'bz}};

  ram dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .isReading (isReading),
    .data      (data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // drive a write: inputs change on the falling edge, commit on the rising edge
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    isReading = 1'b0;
    address   = a;
    drv_val   = v;
    drv_en    = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    drv_en    = 1'b0;
    isReading = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    isReading = 1'b1;
    drv_en    = 1'b0;
    address   = a;
    #1;
    check(tag, data, exp);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    address   = '0;
    isReading = 1'b1;
    drv_val   = '0;
    drv_en    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset state
    read_check("reset_a0",    11'd0,    64'h0);
    read_check("reset_a1023", 11'd1023, 64'h0);
    read_check("reset_a1024", 11'd1024, 64'h0);
    read_check("reset_a2047", 11'd2047, 64'h0);

    // write / read-back
    write_word(11'd1024, 64'hff04);
    check("mem_1024_after_write", dut.ram_memory[1024], 64'hff04);
    read_check("read_1024", 11'd1024, 64'hff04);

    // neighbour isolation across clock edges while reading
    read_check("read_1023_before", 11'd1023, 64'h0);
    repeat (3) @(posedge clk);
    #1;
    check("read_1023_after_clks", data, 64'h0);
    check("mem_1024_stable", dut.ram_memory[1024], 64'hff04);
    check("mem_1025_untouched", dut.ram_memory[1025], 64'h0);

    // boundary addresses and their neighbours
    write_word(11'd0, 64'h0123_4567_89ab_cdef);
    write_word(11'd2047, 64'hfedc_ba98_7654_3210);
    read_check("read_0", 11'd0, 64'h0123_4567_89ab_cdef);
    read_check("read_2047", 11'd2047, 64'hfedc_ba98_7654_3210);
    read_check("read_1_neighbour", 11'd1, 64'h0);
    read_check("read_2046_neighbour", 11'd2046, 64'h0);

    // read follows address with no clock edge
    @(negedge clk);
    address = 11'd0;
    #1;
    check("comb_addr_0", data, 64'h0123_4567_89ab_cdef);
    address = 11'd1024;
    #1;
    check("comb_addr_1024", data, 64'hff04);

    // bus released while writing: external driver's value must appear unaltered
    isReading = 1'b0;
    drv_val   = 64'h0;
    drv_en    = 1'b1;
    #1;
    check("bus_released", data, 64'h0);
    drv_en    = 1'b0;
    isReading = 1'b1;
    #1;
    check("bus_turnaround", data, 64'hff04);

    // no write while reading
    address = 11'd5;
    repeat (2) @(posedge clk);
    #1;
    check("mem_5_no_write", dut.ram_memory[5], 64'h0);
    check("read_5", data, 64'h0);

    // asynchronous reset mid-run
    write_word(11'd2047, 64'hdeadbeef);
    check("mem_2047_deadbeef", dut.ram_memory[2047], 64'hdeadbeef);
    #2;
    reset = 1'b0;
    #1;
    check("async_clear_2047", dut.ram_memory[2047], 64'h0);
    check("async_clear_1024", dut.ram_memory[1024], 64'h0);
    @(negedge clk);
    isReading = 1'b0;
    address   = 11'd2047;
    drv_val   = 64'h1234;
    drv_en    = 1'b1;
    @(posedge clk);
    #1;
    check("write_ignored_in_reset", dut.ram_memory[2047], 64'h0);
    @(negedge clk);
    drv_en    = 1'b0;
    isReading = 1'b1;
    reset     = 1'b1;
    read_check("read_2047_after_reset", 11'd2047, 64'h0);
    write_word(11'd2047, 64'h5555_aaaa_5555_aaaa);
    read_check("write_after_reset", 11'd2047, 64'h5555_aaaa_5555_aaaa);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
